// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// The master side drives the strobes and mux selects. The slave side supplies the latched instruction word.
interface mc_controller_if;
    logic [31:0] Instr;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  RegDst;
    logic        ALUSrc;
    logic [1:0]  DataSrc;
    logic        RegWrite;
    logic        MemWrite;
    logic [1:0]  NPC_Sel;
    logic [1:0]  ExtOp;
    logic [2:0]  ALUOp;
    logic [2:0]  State;
    logic        Illegal;

    modport master (
        input  Instr,
        output IRWrite, PCWrite, RegDst, ALUSrc, DataSrc, RegWrite, MemWrite,
               NPC_Sel, ExtOp, ALUOp, State, Illegal
    );

    modport slave (
        output Instr,
        input  IRWrite, PCWrite, RegDst, ALUSrc, DataSrc, RegWrite, MemWrite,
               NPC_Sel, ExtOp, ALUOp, State, Illegal
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle control FSM for the datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Strobes are single-cycle pulses decoded from the state and the instruction class.
module mc_controller #(
    parameter int MEM_LAT = 1
) (
    input  logic           Clk,
    input  logic           Reset,
    mc_controller_if.master io_bus
);
    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SLL   = 6'b000000;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        OC_NOP, OC_ADDU, OC_SUBU, OC_JR, OC_ORI, OC_LUI,
        OC_LW, OC_SW, OC_BEQ, OC_J, OC_JAL, OC_ILLEGAL
    } opclass_t;

    state_t        r_state;
    opclass_t      r_opclass;
    logic [CW-1:0] r_cnt;

    opclass_t      w_dec;
    opclass_t      w_sel_cls;
    logic          w_dec_short;
    logic          w_mem_last;

    logic          w_irwrite, w_pcwrite, w_regwrite, w_memwrite, w_illegal;
    logic          w_alusrc;
    logic [1:0]    w_regdst, w_datasrc, w_npc_sel, w_extop;
    logic [2:0]    w_aluop;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred on any path.
        w_dec = OC_ILLEGAL;
        case (io_bus.Instr[31:26])
            OP_RTYPE: begin
                case (io_bus.Instr[5:0])
                    FN_ADDU: w_dec = OC_ADDU;
                    FN_SUBU: w_dec = OC_SUBU;
                    FN_JR:   w_dec = OC_JR;
                    FN_SLL:  w_dec = (io_bus.Instr[10:6] == 5'd0) ? OC_NOP : OC_ILLEGAL;
                    default: w_dec = OC_ILLEGAL;
                endcase
            end
            OP_ORI:  w_dec = OC_ORI;
            OP_LUI:  w_dec = OC_LUI;
            OP_LW:   w_dec = OC_LW;
            OP_SW:   w_dec = OC_SW;
            OP_BEQ:  w_dec = OC_BEQ;
            OP_J:    w_dec = OC_J;
            OP_JAL:  w_dec = OC_JAL;
            default: w_dec = OC_ILLEGAL;
        endcase
    end

    // These classes finish in DECODE and never reach EXEC.
    assign w_dec_short = (w_dec == OC_J)   || (w_dec == OC_JAL) || (w_dec == OC_JR) ||
                         (w_dec == OC_NOP) || (w_dec == OC_ILLEGAL);
    assign w_mem_last  = (r_state == MEM) && (r_cnt == CNT_LAST);

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments only, so every register samples the values from before the edge.
        if (!Reset) begin
            r_state   <= FETCH;
            r_opclass <= OC_NOP;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                FETCH:  r_state <= DECODE;
                DECODE: begin
                    r_opclass <= w_dec;
                    r_state   <= w_dec_short ? FETCH : EXEC;
                end
                EXEC: begin
                    case (r_opclass)
                        OC_ADDU, OC_SUBU, OC_ORI, OC_LUI: r_state <= WB;
                        OC_LW, OC_SW: begin
                            r_state <= MEM;
                            r_cnt   <= '0;
                        end
                        default: r_state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (w_mem_last) begin
                        r_state <= (r_opclass == OC_LW) ? WB : FETCH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    // Selects come from the registered class in EXEC..WB. In DECODE they come from the live decode, and only for jumps.
    always_comb begin
        w_sel_cls = OC_NOP;
        case (r_state)
            DECODE:        w_sel_cls = (w_dec == OC_J || w_dec == OC_JAL || w_dec == OC_JR) ? w_dec : OC_NOP;
            EXEC, MEM, WB: w_sel_cls = r_opclass;
            default:       w_sel_cls = OC_NOP;
        endcase
    end

    always_comb begin
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_illegal  = 1'b0;
        w_regdst   = 2'b00;
        w_alusrc   = 1'b0;
        w_datasrc  = 2'b00;
        w_npc_sel  = 2'b00;
        w_extop    = 2'b00;
        w_aluop    = 3'b000;
        if (Reset) begin
            case (r_state)
                FETCH:  w_irwrite = 1'b1;
                DECODE: begin
                    w_pcwrite  = w_dec_short;
                    w_regwrite = (w_dec == OC_JAL);
                    w_illegal  = (w_dec == OC_ILLEGAL);
                end
                EXEC:   w_pcwrite = (r_opclass == OC_BEQ);
                MEM: begin
                    w_memwrite = w_mem_last && (r_opclass == OC_SW);
                    w_pcwrite  = w_mem_last && (r_opclass == OC_SW);
                end
                WB: begin
                    w_regwrite = 1'b1;
                    w_pcwrite  = 1'b1;
                end
                default: ;
            endcase

            case (w_sel_cls)
                OC_ADDU: w_regdst = 2'b01;
                OC_SUBU: begin
                    w_regdst = 2'b01;
                    w_aluop  = 3'b001;
                end
                OC_ORI: begin
                    w_alusrc = 1'b1;
                    w_aluop  = 3'b010;
                end
                OC_LUI: begin
                    w_alusrc = 1'b1;
                    w_extop  = 2'b10;
                    w_aluop  = 3'b010;
                end
                OC_LW: begin
                    w_alusrc  = 1'b1;
                    w_extop   = 2'b01;
                    w_datasrc = 2'b01;
                end
                OC_SW: begin
                    w_alusrc = 1'b1;
                    w_extop  = 2'b01;
                end
                OC_BEQ: begin
                    w_aluop   = 3'b001;
                    w_npc_sel = 2'b01;
                end
                OC_J:    w_npc_sel = 2'b10;
                OC_JAL: begin
                    w_npc_sel = 2'b10;
                    w_regdst  = 2'b10;
                    w_datasrc = 2'b10;
                end
                OC_JR:   w_npc_sel = 2'b11;
                default: ;
            endcase
        end
    end

    assign io_bus.IRWrite  = w_irwrite;
    assign io_bus.PCWrite  = w_pcwrite;
    assign io_bus.RegWrite = w_regwrite;
    assign io_bus.MemWrite = w_memwrite;
    assign io_bus.Illegal  = w_illegal;
    assign io_bus.RegDst   = w_regdst;
    assign io_bus.ALUSrc   = w_alusrc;
    assign io_bus.DataSrc  = w_datasrc;
    assign io_bus.NPC_Sel  = w_npc_sel;
    assign io_bus.ExtOp    = w_extop;
    assign io_bus.ALUOp    = w_aluop;
    assign io_bus.State    = r_state;
endmodule
